gumnut_seq_ctrl: RTL and testbench
==================================

// Module: gumnut_seq_ctrl
// PURPOSE
//  Second-generation Gumnut control sequencer: multi-cycle FSM driving fetch, decode, execute,
//  memory/port access, write-back and interrupt entry. Adds interrupt-enable state, WAIT/STBY
//  sleep until interrupt, and a bus-ack watchdog. Sits between the instruction register decode
//  fields and the datapath/bus strobes.
// PARAMETERS
//  OP_W        7   opcode field width (encodings below assume 7)
//  FUNC_W      3   sub-function field width
//  ACK_TIMEOUT 15  max cycles waiting for any ack before bus error; 0 disables watchdog
//  IE_RESET    0   interrupt-enable value after reset
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  op_i         in   OP_W    opcode from IR
//  func_i       in   FUNC_W  sub-function from IR
//  int_req_i    in   1       level interrupt request
//  inst_ack_i   in   1       instruction bus ack
//  data_ack_i   in   1       data bus ack
//  port_ack_i   in   1       I/O port bus ack
//  inst_cyc_o   out  1       instruction bus cycle/strobe
//  data_cyc_o   out  1       data bus cycle/strobe
//  data_we_o    out  1       data bus write (stm)
//  port_cyc_o   out  1       port bus cycle/strobe
//  port_we_o    out  1       port bus write (out)
//  pc_en_o      out  1       PC update strobe
//  reg_wr_o     out  1       register-file write enable
//  reg_mux_o    out  2       00 ALU, 01 data bus, 10 port bus
//  alu_en_o     out  1       ALU result/flag capture strobe
//  int_ack_o    out  1       one-cycle interrupt entry pulse
//  ie_o         out  1       current interrupt-enable bit
//  bus_err_o    out  1       one-cycle watchdog expiry pulse
//  state_o      out  4       current state encoding (debug)
// BEHAVIOUR
//  Decode: alu_imm op==7'h00, alu_reg op==7'h01, shift 7'h06, mem 7'h02, jump 7'h1E,
//   branch 7'h3E, misc 7'h7E; anything else illegal. mem func 0 stm,1 ldm,2 inp,3 out.
//   misc func 0 ret,1 reti,2 enai,3 disi,4 wait,5 stby. inter = int_req_i & ie.
//  States: RST,FETCH,DECODE,EXECUTE,MEM,WB,INT,SLEEP. Async reset -> RST, ie=IE_RESET,
//   timer=0; every output 0 in RST. RST->FETCH next cycle unconditionally.
//  FETCH: inst_cyc_o=1; stay until inst_ack_i; on ack pc_en_o=1, ->DECODE.
//  DECODE: branch/jump/ret/reti/enai/disi complete here (pc_en_o=1 for branch/jump/ret/reti);
//   enai sets ie, disi clears ie, reti sets ie (all at DECODE exit); ->INT if inter else FETCH.
//   wait/stby -> SLEEP. alu/shift/mem -> EXECUTE. Illegal -> INT if inter else FETCH (NOP).
//  EXECUTE: alu/shift: alu_en_o=1 -> WB. mem: assert bus strobe (+we for stm/out); if ack this
//   cycle -> WB (ldm/inp) or INT/FETCH (stm/out) per inter; else -> MEM.
//  MEM: hold strobes; same exit rules as EXECUTE on ack; else stay.
//  WB: reg_wr_o=1, reg_mux_o per instruction class; -> INT if inter else FETCH.
//  INT: int_ack_o=1, ie cleared, pc_en_o=1; -> FETCH. Only entered at instruction boundary.
//  SLEEP: all strobes 0; leave to INT when int_req_i & ie; stays forever if ie=0 (reset only).
//  Watchdog: counter clears on every state change; counts cycles in FETCH/EXECUTE/MEM
//   while strobe high and no ack. On reaching ACK_TIMEOUT: bus_err_o=1 for that cycle,
//   strobes drop, -> FETCH (instruction abandoned, no reg write, no INT). Ack in the expiry
//   cycle wins: normal transition, no bus_err_o.
//  Acks on buses not currently strobed are ignored. Strobes/reg_wr_o are Moore (state+IR
//   decode); IR fields must be stable from DECODE until instruction end.
//  Latency: ALU op 4 cycles with zero-wait acks (FETCH,DECODE,EXECUTE,WB); stm 3; ldm 4.
// STRUCTURE
//  gumnut_ctrl_pkg: state_t enum, opcode/func localparams, reg_mux codes.
//  Sub-module gumnut_ack_timer: watchdog counter ($clog2(ACK_TIMEOUT+1) bits), clear/
//   enable in, expired out; tied off when ACK_TIMEOUT==0.
// TESTING
//  1 reset mid-MEM (ldm, no ack) -> state RST, all outputs 0; FETCH asserted 1 cycle after release.
//  2 alu_imm func 0, immediate acks -> inst_cyc_o@c0, alu_en_o@c2, reg_wr_o,reg_mux_o=00@c3.
//  3 ldm with data_ack_i after 3 wait cycles -> data_cyc_o 4 cycles, reg_mux_o=01 in WB.
//  4 enai then int_req_i during alu op -> WB->INT, int_ack_o 1 cycle, ie_o drops, then FETCH.
//  5 wait with ie=1, int_req_i after 10 cycles -> SLEEP 10 cycles, then INT, no strobes meanwhile.
//  6 ACK_TIMEOUT=15, no inst_ack_i -> bus_err_o at 15th wait cycle, back to FETCH; ack on that
//    cycle instead -> DECODE, no bus_err_o.

Source files
------------

// File: rtl/gumnut_seq_ctrl_pkg.sv
// Shared types and encodings for the Gumnut control sequencer.
// Opcode and function encodings below assume a 7-bit opcode and a 3-bit function field.
package gumnut_seq_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXECUTE = 4'd3,
    S_MEM     = 4'd4,
    S_WB      = 4'd5,
    S_INT     = 4'd6,
    S_SLEEP   = 4'd7
  } state_t;

  typedef enum logic [2:0] {C_ILL, C_ALU, C_MEM, C_JMP, C_MISC} cls_t;

  localparam logic [6:0] OP_ALU_IMM = 7'h00;
  localparam logic [6:0] OP_ALU_REG = 7'h01;
  localparam logic [6:0] OP_MEM     = 7'h02;
  localparam logic [6:0] OP_SHIFT   = 7'h06;
  localparam logic [6:0] OP_JUMP    = 7'h1E;
  localparam logic [6:0] OP_BRANCH  = 7'h3E;
  localparam logic [6:0] OP_MISC    = 7'h7E;

  localparam logic [2:0] F_STM = 3'd0, F_LDM = 3'd1, F_INP = 3'd2, F_OUT = 3'd3;
  localparam logic [2:0] F_RET = 3'd0, F_RETI = 3'd1, F_ENAI = 3'd2, F_DISI = 3'd3,
                         F_WAIT = 3'd4, F_STBY = 3'd5;

  localparam logic [1:0] MUX_ALU = 2'b00, MUX_DATA = 2'b01, MUX_PORT = 2'b10;

  // Unused mem/misc function codes fall into the illegal class and execute as a NOP.
  function automatic cls_t op_class(input logic [6:0] op, input logic [2:0] func);
    case (op)
      OP_ALU_IMM, OP_ALU_REG, OP_SHIFT: op_class = C_ALU;
      OP_MEM:                           op_class = (func <= F_OUT) ? C_MEM : C_ILL;
      OP_JUMP, OP_BRANCH:               op_class = C_JMP;
      OP_MISC:                          op_class = (func <= F_STBY) ? C_MISC : C_ILL;
      default:                          op_class = C_ILL;
    endcase
  endfunction

endpackage

// File: rtl/gumnut_ack_timer.sv
// Bus-ack watchdog: counts stalled cycles and flags the cycle in which the limit is reached.
module gumnut_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (ACK_TIMEOUT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - 1);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + W'(1);
    end

    // cnt holds the stalled cycles already seen, so the Nth stall cycle sees N-1.
    assign expired = en && (cnt == LAST);
  end

endmodule

// File: rtl/gumnut_seq_ctrl.sv
// Gumnut multi-cycle control sequencer: fetch/decode/execute/mem/write-back,
// interrupt entry, sleep-until-interrupt and bus-ack watchdog.
module gumnut_seq_ctrl
  import gumnut_seq_ctrl_pkg::*;
#(
  parameter int          OP_W        = 7,
  parameter int          FUNC_W      = 3,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter bit          IE_RESET    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   op_i,
  input  logic [FUNC_W-1:0] func_i,
  input  logic              int_req_i,
  input  logic              inst_ack_i,
  input  logic              data_ack_i,
  input  logic              port_ack_i,
  output logic              inst_cyc_o,
  output logic              data_cyc_o,
  output logic              data_we_o,
  output logic              port_cyc_o,
  output logic              port_we_o,
  output logic              pc_en_o,
  output logic              reg_wr_o,
  output logic [1:0]        reg_mux_o,
  output logic              alu_en_o,
  output logic              int_ack_o,
  output logic              ie_o,
  output logic              bus_err_o,
  output logic [3:0]        state_o
);

  state_t     state, state_nx;
  logic       ie, ie_nx;
  cls_t       cls;
  logic [2:0] fn;
  logic       inter, on_data, mem_ack, is_load, stall, expired;
  state_t     boundary;

  assign fn       = 3'(func_i);
  assign cls      = op_class(7'(op_i), fn);
  assign inter    = int_req_i & ie;
  assign boundary = inter ? S_INT : S_FETCH;
  assign on_data  = (fn == F_STM) || (fn == F_LDM);
  assign mem_ack  = on_data ? data_ack_i : port_ack_i;
  assign is_load  = (fn == F_LDM) || (fn == F_INP);

  // Only the bus currently strobed can end a stall; other acks are ignored.
  always_comb begin
    stall = 1'b0;
    case (state)
      S_FETCH:          stall = !inst_ack_i;
      S_EXECUTE, S_MEM: stall = (cls == C_MEM) && !mem_ack;
      default:          stall = 1'b0;
    endcase
  end

  gumnut_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state_nx != state) || expired),
    .en      (stall),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
      ie    <= IE_RESET;
    end else begin
      state <= state_nx;
      ie    <= ie_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ie_nx    = ie;
    case (state)
      S_RST:   state_nx = S_FETCH;
      S_FETCH: state_nx = inst_ack_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (cls)
          C_ALU, C_MEM: state_nx = S_EXECUTE;
          C_MISC: begin
            if (fn == F_WAIT || fn == F_STBY) state_nx = S_SLEEP;
            else                              state_nx = boundary;
            if (fn == F_ENAI || fn == F_RETI) ie_nx = 1'b1;
            if (fn == F_DISI)                 ie_nx = 1'b0;
          end
          default: state_nx = boundary;
        endcase
      end
      S_EXECUTE, S_MEM: begin
        if (cls == C_ALU)  state_nx = S_WB;
        else if (mem_ack)  state_nx = is_load ? S_WB : boundary;
        else if (expired)  state_nx = S_FETCH;
        else               state_nx = S_MEM;
      end
      S_WB: state_nx = boundary;
      S_INT: begin
        state_nx = S_FETCH;
        ie_nx    = 1'b0;
      end
      S_SLEEP: if (inter) state_nx = S_INT;
      default: state_nx = S_RST;
    endcase
  end

  always_comb begin
    inst_cyc_o = 1'b0;
    data_cyc_o = 1'b0;
    data_we_o  = 1'b0;
    port_cyc_o = 1'b0;
    port_we_o  = 1'b0;
    pc_en_o    = 1'b0;
    reg_wr_o   = 1'b0;
    reg_mux_o  = MUX_ALU;
    alu_en_o   = 1'b0;
    int_ack_o  = 1'b0;
    case (state)
      S_FETCH: begin
        inst_cyc_o = 1'b1;
        pc_en_o    = inst_ack_i;
      end
      S_DECODE: pc_en_o = (cls == C_JMP) ||
                          ((cls == C_MISC) && (fn == F_RET || fn == F_RETI));
      S_EXECUTE, S_MEM: begin
        alu_en_o   = (state == S_EXECUTE) && (cls == C_ALU);
        data_cyc_o = (cls == C_MEM) && on_data;
        data_we_o  = (cls == C_MEM) && (fn == F_STM);
        port_cyc_o = (cls == C_MEM) && !on_data;
        port_we_o  = (cls == C_MEM) && (fn == F_OUT);
      end
      S_WB: begin
        reg_wr_o  = 1'b1;
        reg_mux_o = (cls == C_ALU) ? MUX_ALU : (fn == F_LDM) ? MUX_DATA : MUX_PORT;
      end
      S_INT: begin
        int_ack_o = 1'b1;
        pc_en_o   = 1'b1;
      end
      default: ;
    endcase
  end

  assign ie_o      = ie;
  assign bus_err_o = expired;
  assign state_o   = state;

endmodule

// File: tb/tb_gumnut_seq_ctrl.sv
// Directed bench for gumnut_seq_ctrl: per-cycle vector table plus hand sequences
// for watchdog expiry, sleep without interrupt enable and reset during a memory access.
module tb_gumnut_seq_ctrl;

  localparam logic [3:0] RST = 4'd0, FET = 4'd1, DEC = 4'd2, EXE = 4'd3,
                         MEM = 4'd4, WB = 4'd5, INT = 4'd6, SLP = 4'd7;

  // Expected-output bit masks, order matches the outs concatenation below.
  localparam logic [12:0] INST = 13'h1000, DCYC = 13'h0800, DWE  = 13'h0400,
                          PCYC = 13'h0200, PWE  = 13'h0100, PCEN = 13'h0080,
                          RWR  = 13'h0040, MPORT = 13'h0020, MDATA = 13'h0010,
                          ALUE = 13'h0008, IACK = 13'h0004, IE   = 13'h0002,
                          BERR = 13'h0001, NONE = 13'h0000;

  localparam logic [6:0] O_ALUI = 7'h00, O_ALUR = 7'h01, O_MEM = 7'h02,
                         O_JMP = 7'h1E, O_BR = 7'h3E, O_MISC = 7'h7E, O_ILL = 7'h05;

  logic       clk, rst_n, int_req, inst_ack, data_ack, port_ack;
  logic [6:0] op;
  logic [2:0] fn;
  logic       inst_cyc, data_cyc, data_we, port_cyc, port_we, pc_en, reg_wr;
  logic       alu_en, int_ack, ie, bus_err;
  logic [1:0] reg_mux;
  logic [3:0] state;
  logic [12:0] outs;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  fn;
    logic        irq;
    logic [2:0]  acks;  // {inst, data, port}
    logic [3:0]  es;
    logic [12:0] eo;
  } vec_t;

  vec_t tbl[$];

  gumnut_seq_ctrl #(.OP_W(7), .FUNC_W(3), .ACK_TIMEOUT(15), .IE_RESET(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op), .func_i(fn), .int_req_i(int_req),
    .inst_ack_i(inst_ack), .data_ack_i(data_ack), .port_ack_i(port_ack),
    .inst_cyc_o(inst_cyc), .data_cyc_o(data_cyc), .data_we_o(data_we),
    .port_cyc_o(port_cyc), .port_we_o(port_we), .pc_en_o(pc_en), .reg_wr_o(reg_wr),
    .reg_mux_o(reg_mux), .alu_en_o(alu_en), .int_ack_o(int_ack), .ie_o(ie),
    .bus_err_o(bus_err), .state_o(state)
  );

  assign outs = {inst_cyc, data_cyc, data_we, port_cyc, port_we, pc_en, reg_wr,
                 reg_mux, alu_en, int_ack, ie, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f,
                     input logic irq, input logic [2:0] acks,
                     input logic [3:0] es, input logic [12:0] eo);
    vec_t v;
    v.rst_n = r; v.op = o; v.fn = f; v.irq = irq; v.acks = acks; v.es = es; v.eo = eo;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [6:0] o, input logic [2:0] f,
                       input logic irq, input logic [2:0] acks);
    rst_n = r; op = o; fn = f; int_req = irq;
    {inst_ack, data_ack, port_ack} = acks;
  endtask

  task automatic check(input string nm, input logic [3:0] es, input logic [12:0] eo);
    n_chk++;
    if (state !== es || outs !== eo)
      $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
               nm, state, outs, es, eo);
    else
      n_pass++;
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic cyc(input string nm, input logic [3:0] es, input logic [12:0] eo);
    #1 check(nm, es, eo);
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 7'h00, 3'd0, 1'b0, 3'b000);

    // reset, then alu_imm with immediate acks
    add(0, O_ALUI, 0, 0, 3'b000, RST, NONE);
    add(1, O_ALUI, 0, 0, 3'b000, RST, NONE);
    add(1, O_ALUI, 0, 0, 3'b100, FET, INST | PCEN);
    add(1, O_ALUI, 0, 0, 3'b000, DEC, NONE);
    add(1, O_ALUI, 0, 0, 3'b000, EXE, ALUE);
    add(1, O_ALUI, 0, 0, 3'b000, WB,  RWR);
    // ldm, data ack after three wait cycles; stray port/inst acks ignored
    add(1, O_MEM, 1, 0, 3'b100, FET, INST | PCEN);
    add(1, O_MEM, 1, 0, 3'b100, DEC, NONE);
    add(1, O_MEM, 1, 0, 3'b001, EXE, DCYC);
    add(1, O_MEM, 1, 0, 3'b000, MEM, DCYC);
    add(1, O_MEM, 1, 0, 3'b000, MEM, DCYC);
    add(1, O_MEM, 1, 0, 3'b010, MEM, DCYC);
    add(1, O_MEM, 1, 0, 3'b000, WB,  RWR | MDATA);
    // stm, zero-wait: three cycles
    add(1, O_MEM, 0, 0, 3'b100, FET, INST | PCEN);
    add(1, O_MEM, 0, 0, 3'b000, DEC, NONE);
    add(1, O_MEM, 0, 0, 3'b010, EXE, DCYC | DWE);
    // out, data ack ignored, port ack in MEM
    add(1, O_MEM, 3, 0, 3'b100, FET, INST | PCEN);
    add(1, O_MEM, 3, 0, 3'b000, DEC, NONE);
    add(1, O_MEM, 3, 0, 3'b010, EXE, PCYC | PWE);
    add(1, O_MEM, 3, 0, 3'b001, MEM, PCYC | PWE);
    // inp, zero-wait
    add(1, O_MEM, 2, 0, 3'b100, FET, INST | PCEN);
    add(1, O_MEM, 2, 0, 3'b000, DEC, NONE);
    add(1, O_MEM, 2, 0, 3'b001, EXE, PCYC);
    add(1, O_MEM, 2, 0, 3'b000, WB,  RWR | MPORT);
    // enai, then interrupt request during an alu_reg op
    add(1, O_MISC, 2, 0, 3'b100, FET, INST | PCEN);
    add(1, O_MISC, 2, 0, 3'b000, DEC, NONE);
    add(1, O_ALUR, 0, 0, 3'b100, FET, INST | PCEN | IE);
    add(1, O_ALUR, 0, 1, 3'b000, DEC, IE);
    add(1, O_ALUR, 0, 1, 3'b000, EXE, ALUE | IE);
    add(1, O_ALUR, 0, 1, 3'b000, WB,  RWR | IE);
    add(1, O_ALUR, 0, 1, 3'b000, INT, IACK | PCEN | IE);
    add(1, O_ALUR, 0, 1, 3'b000, FET, INST);
    // branch, jump, ret, reti (sets ie), disi with pending request
    add(1, O_BR,   0, 0, 3'b100, FET, INST | PCEN);
    add(1, O_BR,   0, 0, 3'b000, DEC, PCEN);
    add(1, O_JMP,  0, 0, 3'b100, FET, INST | PCEN);
    add(1, O_JMP,  0, 0, 3'b000, DEC, PCEN);
    add(1, O_MISC, 0, 0, 3'b100, FET, INST | PCEN);
    add(1, O_MISC, 0, 0, 3'b000, DEC, PCEN);
    add(1, O_MISC, 1, 0, 3'b100, FET, INST | PCEN);
    add(1, O_MISC, 1, 0, 3'b000, DEC, PCEN);
    add(1, O_MISC, 3, 0, 3'b100, FET, INST | PCEN | IE);
    add(1, O_MISC, 3, 1, 3'b000, DEC, IE);
    add(1, O_MISC, 3, 1, 3'b000, INT, IACK | PCEN);
    // illegal opcode is a NOP; ie is clear so no interrupt entry
    add(1, O_ILL,  0, 1, 3'b100, FET, INST | PCEN);
    add(1, O_ILL,  0, 1, 3'b000, DEC, NONE);
    // enai, then wait: sleep ten cycles, stray acks ignored, wake on request
    add(1, O_MISC, 2, 0, 3'b100, FET, INST | PCEN);
    add(1, O_MISC, 2, 0, 3'b000, DEC, NONE);
    add(1, O_MISC, 4, 0, 3'b100, FET, INST | PCEN | IE);
    add(1, O_MISC, 4, 0, 3'b000, DEC, IE);
    for (int i = 0; i < 9; i++) add(1, O_MISC, 4, 0, 3'b111, SLP, IE);
    add(1, O_MISC, 4, 1, 3'b000, SLP, IE);
    add(1, O_MISC, 4, 1, 3'b000, INT, IACK | PCEN | IE);
    add(1, O_MISC, 4, 0, 3'b000, FET, INST);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].op, tbl[i].fn, tbl[i].irq, tbl[i].acks);
      cyc($sformatf("vec%0d", i), tbl[i].es, tbl[i].eo);
    end

    // Watchdog on the instruction bus: expiry on the 15th stalled cycle, then a fresh window
    // where an ack on the 15th cycle wins.
    drive(0, O_MEM, 1, 0, 3'b000); cyc("wd_rst", RST, NONE);
    drive(1, O_MEM, 1, 0, 3'b000); cyc("wd_rst_rel", RST, NONE);
    for (int i = 1; i <= 15; i++)
      cyc($sformatf("wd_fetch%0d", i), FET, (i == 15) ? (INST | BERR) : INST);
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) drive(1, O_MEM, 1, 0, 3'b100);
      cyc($sformatf("wd_ackwin%0d", i), FET, (i == 15) ? (INST | PCEN) : INST);
    end
    drive(1, O_MEM, 1, 0, 3'b000); cyc("wd_dec", DEC, NONE);
    // Watchdog on the data bus: EXECUTE stall then a full window in MEM, no write-back.
    cyc("wd_exe", EXE, DCYC);
    for (int i = 1; i <= 15; i++)
      cyc($sformatf("wd_mem%0d", i), MEM, (i == 15) ? (DCYC | BERR) : DCYC);
    cyc("wd_abandon", FET, INST);

    // stby with ie clear: request is ignored, sleep holds
    drive(1, O_MISC, 5, 1, 3'b100); cyc("stby_fet", FET, INST | PCEN);
    drive(1, O_MISC, 5, 1, 3'b000); cyc("stby_dec", DEC, NONE);
    for (int i = 0; i < 5; i++) cyc($sformatf("stby_slp%0d", i), SLP, NONE);

    // Reset asserted mid-MEM of an ldm with no ack
    drive(0, O_MEM, 1, 0, 3'b000); cyc("r1_rst", RST, NONE);
    drive(1, O_MEM, 1, 0, 3'b000); cyc("r1_rel", RST, NONE);
    drive(1, O_MEM, 1, 0, 3'b100); cyc("r1_fet", FET, INST | PCEN);
    drive(1, O_MEM, 1, 0, 3'b000); cyc("r1_dec", DEC, NONE);
    cyc("r1_exe", EXE, DCYC);
    cyc("r1_mem", MEM, DCYC);
    #3 rst_n = 1'b0;
    #1 check("r1_async_rst", RST, NONE);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("r1_after_rel", RST, NONE);
    cyc("r1_fetch", FET, INST);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
